// File: rtl/l2_cache_control.sv
// Control FSM sequencing the L2 datapath: tag check, dirty-victim writeback, line fill.
// Define L2_PERF_CNT_EN to add saturating hit/miss/writeback counters.
module l2_cache_control
`ifdef L2_PERF_CNT_EN
#(
    parameter int CNT_WIDTH = 32
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_read,
    input  logic       mem_write,
    output logic       mem_resp,
    output logic       pmem_read,
    output logic       pmem_write,
    input  logic       pmem_resp,
    input  logic       cache_hit,
    input  logic [2:0] hit_idx,
    input  logic [2:0] plru_idx,
    input  logic       dirty_o,
    output logic       source_sel,
    output logic [2:0] way_sel,
    output logic       tag_sel,
    output logic [2:0] dirty_sel,
    output logic       load_cache,
    output logic       load_dirty_arr,
    output logic       load_lru,
    output logic       read_cache_data
`ifdef L2_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
`endif
);

    // state        | meaning
    // IDLE         | waiting for an L1 request
    // TAG_CHECK    | compare tags; hit completes, miss picks the PLRU victim
    // WRITEBACK    | dirty victim line written to memory
    // FILL         | requested line read from memory into the victim way
    // FILL_SETTLE  | array write propagates before the re-check
    // DONE         | masks the still-held request for one cycle
    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_TAG_CHECK   = 3'd1;
    localparam logic [2:0] S_WRITEBACK   = 3'd2;
    localparam logic [2:0] S_FILL        = 3'd3;
    localparam logic [2:0] S_FILL_SETTLE = 3'd4;
    localparam logic [2:0] S_DONE        = 3'd5;

    logic [2:0] state;
    logic [2:0] state_next;
    logic [2:0] victim_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            victim_q <= '0;
        end else begin
            state <= state_next;
            if (state == S_TAG_CHECK && !cache_hit) begin
                victim_q <= plru_idx;
            end
        end
    end

    always_comb begin
        state_next     = state;
        mem_resp       = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        source_sel     = 1'b0;
        way_sel        = '0;
        tag_sel        = 1'b0;
        dirty_sel      = '0;
        load_cache     = 1'b0;
        load_dirty_arr = 1'b0;
        load_lru       = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    state_next = S_TAG_CHECK;
                end
            end
            S_TAG_CHECK: begin
                dirty_sel = plru_idx;
                way_sel   = hit_idx;
                if (cache_hit) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    // A write takes priority when both requests are raised.
                    if (mem_write) begin
                        load_cache     = 1'b1;
                        load_dirty_arr = 1'b1;
                    end
                    state_next = S_DONE;
                end else if (dirty_o) begin
                    state_next = S_WRITEBACK;
                end else begin
                    state_next = S_FILL;
                end
            end
            S_WRITEBACK: begin
                way_sel    = victim_q;
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    state_next = S_FILL;
                end
            end
            S_FILL: begin
                way_sel    = victim_q;
                tag_sel    = 1'b1;
                source_sel = 1'b1;
                pmem_read  = 1'b1;
                if (pmem_resp) begin
                    // No array write if reset lands on the response cycle.
                    load_cache     = rst;
                    load_dirty_arr = rst;
                    state_next     = S_FILL_SETTLE;
                end
            end
            S_FILL_SETTLE: state_next = S_TAG_CHECK;
            S_DONE:        state_next = S_IDLE;
            default:       state_next = S_IDLE;
        endcase
    end

    assign read_cache_data = 1'b1;

`ifdef L2_PERF_CNT_EN
    // Set only while in the TAG_CHECK that follows a fill, which is not counted.
    logic recheck_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            recheck_q  <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            recheck_q <= (state == S_FILL_SETTLE);
            if (state == S_TAG_CHECK && !recheck_q) begin
                if (cache_hit) begin
                    if (hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
                end else begin
                    if (miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
                    if (dirty_o && wb_count != '1) wb_count <= wb_count + CNT_WIDTH'(1);
                end
            end
        end
    end
`endif

endmodule
